// File: rtl/seq_detector_param.sv
`timescale 1ns/1ps
// seq_detector_param
// Parametrised serial pattern detector for a 1-bit data stream.
// Flags each occurrence of PATTERN, with the first received bit in
// PATTERN[PAT_LEN-1]. It also keeps a saturating count of matches.
//
// Parameters:
//   PAT_LEN - pattern length in bits (2..16)
//   PATTERN - pattern to detect, PAT_LEN bits, MSB received first
//   OVERLAP - 1: matches may share bits; 0: history restarts after a match
//   CNT_W   - width of match_count (1..32)
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   en          - DIN carries a valid stream bit this cycle
//   DIN         - serial data bit
//   clear       - synchronous clear of match_count and count_sat
//   FOUND       - combinational: the current accepted DIN completes PATTERN
//   match_count - registered saturating count of matches since reset/clear
//   count_sat   - registered flag: match_count is all-ones

module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             DIN,
    input  logic             clear,
    output logic             FOUND,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    // vld counts 0..PAT_LEN-1, so $clog2(PAT_LEN) bits are enough.
    localparam int                 VLD_W    = $clog2(PAT_LEN);
    localparam logic [VLD_W-1:0]   VLD_FULL = VLD_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [VLD_W-1:0]   vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [PAT_LEN-1:0] window;
    logic               found;

    // The candidate window is the stored history followed by the incoming bit.
    // The && on en keeps an unknown DIN from reaching FOUND while en is low.
    always_comb begin
        window = {hist_q, DIN};
        found  = en && (vld_q == VLD_FULL) && (window == PATTERN);
    end

    // History advances only on accepted bits. Slicing the window, rather than
    // slicing hist, keeps the shift legal when PAT_LEN is 2 and hist is one bit.
    always_comb begin
        hist_d = hist_q;
        vld_d  = vld_q;
        if (en) begin
            if (found && !OVERLAP) begin
                hist_d = '0;
                vld_d  = '0;
            end else begin
                hist_d = window[PAT_LEN-2:0];
                if (vld_q != VLD_FULL) begin
                    vld_d = vld_q + 1'b1;
                end
            end
        end
    end

    // Clear takes priority over a coincident match. The saturation flag follows
    // the next count value, so it rises on the same edge the count reaches all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (found && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign FOUND       = found;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
`timescale 1ns/1ps
// tb_seq_detector_param
// Drives four detector configurations from one shared stream:
//   u0: 0101, overlapping, 8-bit count
//   u1: 0101, non-overlapping, 8-bit count
//   u2: 0101, overlapping, 2-bit count (saturates at 3)
//   u3: 111 (3 bits), overlapping, 8-bit count
// A stream-level model predicts every output each cycle. Hand-computed
// expectations pin the model to known results.

module tb_seq_detector_param;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic reset, en, DIN, clear;

    logic [NI-1:0] found;
    logic [NI-1:0] sat;
    logic [7:0]    cnt0, cnt1, cnt3;
    logic [1:0]    cnt2;
    logic [31:0]   actCnt [NI];

    int total = 0;
    int bad   = 0;

    // Per-instance configuration, as seen by the model.
    int cfgLen [NI] = '{4, 4, 4, 3};
    int cfgPat [NI] = '{5, 5, 5, 7};
    bit cfgOvl [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cfgMax [NI] = '{255, 255, 3, 255};

    // Model state: every accepted bit since reset, plus, for each instance,
    // where its usable history starts after a non-overlapping match.
    bit stream [$];
    int startIdx [NI];
    int expCnt [NI];
    bit expSat [NI];

    logic [15:0] fvec [NI];

    always #10 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .en(en), .DIN(DIN), .clear(clear),
        .FOUND(found[0]), .match_count(cnt0), .count_sat(sat[0]));

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .DIN(DIN), .clear(clear),
        .FOUND(found[1]), .match_count(cnt1), .count_sat(sat[1]));

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .en(en), .DIN(DIN), .clear(clear),
        .FOUND(found[2]), .match_count(cnt2), .count_sat(sat[2]));

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .en(en), .DIN(DIN), .clear(clear),
        .FOUND(found[3]), .match_count(cnt3), .count_sat(sat[3]));

    assign actCnt[0] = 32'(cnt0);
    assign actCnt[1] = 32'(cnt1);
    assign actCnt[2] = 32'(cnt2);
    assign actCnt[3] = 32'(cnt3);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // An instance matches when the last PAT_LEN bits, including the new one,
    // spell the pattern. Only bits at or after its restart point count.
    function automatic bit modelMatch(input int k, input bit nb);
        int n;
        int len;
        bit b;
        n   = stream.size() + 1;
        len = cfgLen[k];
        if (n - startIdx[k] < len) return 1'b0;
        for (int i = 0; i < len; i++) begin
            b = (i == len - 1) ? nb : stream[n - len + i];
            if (b != bit'((cfgPat[k] >> (len - 1 - i)) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Per-cycle compare. Inputs change on the falling edge, so 2 ns later
    // FOUND reflects the current inputs and the registers reflect the last rising edge.
    // The model then advances to its state after the coming rising edge.
    always @(negedge clk) begin
        bit m [NI];
        #2;
        if (reset) begin
            stream.delete();
            for (int k = 0; k < NI; k++) begin
                startIdx[k] = 0;
                expCnt[k]   = 0;
                expSat[k]   = 1'b0;
            end
        end
        for (int k = 0; k < NI; k++) begin
            m[k] = (!reset && en) ? modelMatch(k, DIN) : 1'b0;
            checkOutput($sformatf("u%0d FOUND", k), 32'(found[k]), 32'(m[k]));
            checkOutput($sformatf("u%0d match_count", k), actCnt[k], 32'(expCnt[k]));
            checkOutput($sformatf("u%0d count_sat", k), 32'(sat[k]), 32'(expSat[k]));
        end
        if (!reset) begin
            if (en) stream.push_back(DIN);
            for (int k = 0; k < NI; k++) begin
                if (m[k] && !cfgOvl[k]) startIdx[k] = stream.size();
                if (clear) expCnt[k] = 0;
                else if (m[k] && expCnt[k] < cfgMax[k]) expCnt[k]++;
                expSat[k] = (expCnt[k] == cfgMax[k]);
            end
        end
    end

    // Drive one cycle of inputs on the falling edge. Sample FOUND 4 ns later
    // and append it to each instance's history vector.
    task automatic applyStimulus(input logic r, input logic e, input logic d, input logic c);
        @(negedge clk);
        reset = r;
        en    = e;
        DIN   = d;
        clear = c;
        #4;
        for (int k = 0; k < NI; k++) fvec[k] = {fvec[k][14:0], found[k]};
    endtask

    task automatic clearVec();
        for (int k = 0; k < NI; k++) fvec[k] = '0;
    endtask

    task automatic sendStream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expC2 [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
        reset = 1'b1;
        en    = 1'b0;
        DIN   = 1'b0;
        clear = 1'b0;
        clearVec();

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset cnt0", 32'(cnt0), 32'd0);
        checkOutput("reset sat2", 32'(sat[2]), 32'd0);

        // Overlap versus non-overlap on 01010101
        clearVec();
        sendStream(16'b01010101, 8);
        checkOutput("s1 u0 found vec", 32'(fvec[0]), 32'h15);
        checkOutput("s1 u1 found vec", 32'(fvec[1]), 32'h11);
        checkOutput("s1 u2 found vec", 32'(fvec[2]), 32'h15);
        checkOutput("s1 u3 found vec", 32'(fvec[3]), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'bx, 1'b0);
        checkOutput("s1 cnt0", 32'(cnt0), 32'd3);
        checkOutput("s1 cnt1", 32'(cnt1), 32'd2);
        checkOutput("s1 cnt2", 32'(cnt2), 32'd3);
        checkOutput("s1 sat2", 32'(sat[2]), 32'd1);

        // Enable gaps, including DIN unknown and a completing bit while en is low
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        clearVec();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'bx, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s2 u0 found vec", 32'(fvec[0]), 32'h009);
        checkOutput("s2 u1 found vec", 32'(fvec[1]), 32'h008);
        checkOutput("s2 u2 found vec", 32'(fvec[2]), 32'h009);
        checkOutput("s2 u3 found vec", 32'(fvec[3]), 32'h000);

        // Saturation of the 2-bit counter, then clear coincident with a match
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
            checkOutput($sformatf("s3 cnt2 bit%0d", i + 1), 32'(cnt2), 32'(expC2[i]));
            checkOutput($sformatf("s3 sat2 bit%0d", i + 1), 32'(sat[2]), 32'(expC2[i] == 3));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("s3 found0 during clear", 32'(found[0]), 32'd1);
        checkOutput("s3 found2 during clear", 32'(found[2]), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3 cnt2 after clear", 32'(cnt2), 32'd0);
        checkOutput("s3 sat2 after clear", 32'(sat[2]), 32'd0);
        checkOutput("s3 cnt0 after clear", 32'(cnt0), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3 cnt2 post", 32'(cnt2), 32'd1);
        checkOutput("s3 cnt0 post", 32'(cnt0), 32'd1);
        checkOutput("s3 cnt1 post", 32'(cnt1), 32'd1);

        // Reset asserted asynchronously mid-cycle during a partial pattern
        sendStream(16'b1101, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s4 cnt0 before reset", 32'(cnt0), 32'd1);
        #2;
        reset = 1'b1;
        #2;
        checkOutput("s4 async found", 32'(found), 32'd0);
        checkOutput("s4 async cnt0", 32'(cnt0), 32'd0);
        checkOutput("s4 async cnt1", 32'(cnt1), 32'd0);
        checkOutput("s4 async cnt2", 32'(cnt2), 32'd0);
        checkOutput("s4 async sat", 32'(sat), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        clearVec();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s4 found0 first bit", 32'(found[0]), 32'd0);
        sendStream(16'b0101, 4);
        checkOutput("s4 u0 found vec", 32'(fvec[0]), 32'h01);
        checkOutput("s4 u1 found vec", 32'(fvec[1]), 32'h01);
        checkOutput("s4 u3 found vec", 32'(fvec[3]), 32'h00);

        // Three-bit all-ones pattern with overlap
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        clearVec();
        sendStream(16'b11110111, 8);
        checkOutput("s5 u3 found vec", 32'(fvec[3]), 32'h31);
        checkOutput("s5 u0 found vec", 32'(fvec[0]), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s5 cnt3", 32'(cnt3), 32'd3);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, next generation of the fixed 4-bit Mealy sequence detector. The pattern, its length, overlap mode and counter width are set at elaboration time. It adds a bit-valid enable, a saturating match counter with synchronous clear, and a saturation flag. It sits on a 1-bit serial data stream and flags each occurrence of PATTERN, MSB received first.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b0101, pattern to detect, PAT_LEN bits wide; bit PAT_LEN-1 is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts empty after each match.
CNT_W, 8, width of match_count; legal range 1..32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  DIN is a valid stream bit this cycle
DIN  input  1  serial data bit
clear  input  1  synchronous clear of match_count and count_sat
FOUND  output  1  Mealy match flag: current DIN completes PATTERN
match_count  output  CNT_W  registered count of matches since reset/clear, saturating
count_sat  output  1  registered flag: match_count has reached all-ones

Behaviour:
- Single clock domain (clk). Asynchronous active-high reset; one clock; no other resets.
- Internal state:
  - hist: PAT_LEN-1 bits, the most recent accepted bits.
  - vld: 0..PAT_LEN-1, the number of valid bits in hist.
  - An equivalent KMP-style FSM is an acceptable implementation if it gives identical FOUND and count behaviour.
- Reset (async assert): hist=0, vld=0, match_count=0, count_sat=0. FOUND=0 while reset is high.
- Accept: a bit is accepted on a rising clk edge with en=1. With en=0: FOUND=0, hist/vld hold, count holds, DIN is ignored. A stall between bits does not break a partial match.
- FOUND (combinational, zero latency):
  - FOUND = en & (vld==PAT_LEN-1) & ({hist,DIN}==PATTERN).
  - No match is possible until PAT_LEN bits have been accepted after reset.
- History update on an accepted bit:
  - Default: hist <= {hist[PAT_LEN-3:0],DIN}, vld <= min(vld+1, PAT_LEN-1).
  - If FOUND and OVERLAP=0: hist <= 0, vld <= 0 (no bits of the match are reused).
  - If FOUND and OVERLAP=1: default update.
- match_count: increments by 1 on the edge where FOUND=1 and clear=0, and is visible on the following cycle. Once at 2^CNT_W-1 it holds, and count_sat <= 1.
- clear=1: match_count <= 0, count_sat <= 0 on the next edge. Clear wins over a simultaneous match; that match is not counted. Clear does not affect hist/vld, so FOUND and detection continue.
- Reset mid-pattern: partial history is discarded; the bits that follow must supply a full PAT_LEN-bit pattern.
- DIN X while en=0 must not propagate to any output.

Test Plan:
- Overlap default (0101, OVERLAP=1): reset 2 cycles, en=1, DIN 0,1,0,1,0,1 -> FOUND high on bits 4 and 6 only; match_count=2 one cycle after bit 6.
- Non-overlap (OVERLAP=0): same stream -> FOUND on bit 4 only. Then DIN 0,1 -> FOUND on bit 8; match_count=2.
- Enable gaps: DIN 0,1, en=0 for 3 cycles with DIN toggling, then 0,1 -> FOUND on the final bit; FOUND=0 throughout the en=0 cycles.
- Saturation and clear (CNT_W=2): five matches -> match_count 1,2,3,3,3, count_sat=1 after the third. Assert clear coincident with a match -> match_count=0, count_sat=0, no increment.
- Reset mid-pattern: DIN 0,1,0, assert reset asynchronously mid-cycle, release, DIN 1 -> FOUND=0. Then 0,1,0,1 -> FOUND on the last bit; all outputs read 0 during reset.
- Alternate parameters (PAT_LEN=3, PATTERN=3'b111, OVERLAP=1): DIN 1,1,1,1,0,1,1,1 -> FOUND on bits 3, 4 and 8; match_count=3.
